// File: rtl/clock_div_pkg.sv
// Shared parameters and divisor type for the programmable clock divider.
package clock_div_pkg;
  localparam int DIV_W   = 32;
  localparam int MIN_DIV = 2;
  typedef logic [DIV_W-1:0] div_t;
endpackage

// File: rtl/clock_div_counter.sv
// Period counter: holds the latched divisor, phase split and boundary detect.
import clock_div_pkg::*;

module clock_div_counter #(
  parameter int DIV_W   = clock_div_pkg::DIV_W,
  parameter int MIN_DIV = clock_div_pkg::MIN_DIV
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [DIV_W-1:0] neff,
  output logic             boundary,
  output logic             high_phase
);

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] MIN_V = DIV_W'(MIN_DIV);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] hi;
  logic [DIV_W-1:0] cnt_nxt;
  logic             start;

  // cnt never exceeds div-1 outside a boundary, so cnt_nxt cannot wrap
  // where it is actually used.
  assign cnt_nxt    = cnt + ONE;
  assign boundary   = start | (cnt == div - ONE);
  assign high_phase = cnt_nxt < hi;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      div   <= MIN_V;
      hi    <= ONE;
      start <= 1'b1;
    end else if (boundary) begin
      cnt   <= '0;
      div   <= neff;
      hi    <= (neff >> 1) + DIV_W'(neff[0]);
      start <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/clock_div_mod.sv
// Programmable integer clock divider; divisor retunes only at period edges.
import clock_div_pkg::*;

module clock_div_mod #(
  parameter int DIV_W   = clock_div_pkg::DIV_W,
  parameter int MIN_DIV = clock_div_pkg::MIN_DIV
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [DIV_W-1:0] FREQ_VAL,
  output logic             clk_out
);

  localparam logic [DIV_W-1:0] MIN_V = DIV_W'(MIN_DIV);

  logic [DIV_W-1:0] neff;
  logic             boundary;
  logic             high_phase;

  assign neff = (FREQ_VAL < MIN_V) ? MIN_V : FREQ_VAL;

  clock_div_counter #(
    .DIV_W   (DIV_W),
    .MIN_DIV (MIN_DIV)
  ) u_counter (
    .clk_in     (clk_in),
    .reset      (reset),
    .neff       (neff),
    .boundary   (boundary),
    .high_phase (high_phase)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      clk_out <= 1'b0;
    end else begin
      clk_out <= boundary | high_phase;
    end
  end

endmodule

// File: tb/tb_clock_div_mod.sv
// Self-checking bench: random and directed divisors against a phase-count model.
module tb_clock_div_mod;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b0;
  logic [31:0] freq   = 32'd4;
  logic        clk_out;

  int checks   = 0;
  int failures = 0;

  // reference: remaining high/low cycles of the current period
  longint unsigned ones_left  = 0;
  longint unsigned zeros_left = 0;
  longint unsigned pos        = 0;
  longint unsigned n_cur      = 2;
  bit              fresh      = 1'b1;
  logic            exp_out    = 1'b0;

  clock_div_mod dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .FREQ_VAL (freq),
    .clk_out  (clk_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [31:0] f);
    if (fresh || (ones_left + zeros_left == 0)) begin
      n_cur      = (f < 32'd2) ? 64'd2 : {32'd0, f};
      ones_left  = (n_cur + 1) / 2;
      zeros_left = n_cur - ones_left;
      fresh      = 1'b0;
      pos        = 0;
    end else begin
      pos++;
    end
    if (ones_left > 0) begin
      exp_out = 1'b1;
      ones_left--;
    end else begin
      exp_out = 1'b0;
      zeros_left--;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk_in);
    if (reset) model_edge(freq);
    else exp_out = 1'b0;
    #1;
    check(tag, {63'd0, clk_out}, {63'd0, exp_out});
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // short async pulse issued 1 unit after an edge, released before the next
  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    fresh = 1'b1;
    #1;
    check(tag, {63'd0, clk_out}, 64'd0);
    #4;
    reset = 1'b1;
  endtask

  initial begin
    // N=4 held in reset for 8 cycles
    freq  = 32'd4;
    reset = 1'b0;
    run("in_reset", 8);
    @(negedge clk_in);
    reset = 1'b1;
    run("n4", 12);

    // change to 9 mid-period: the 4-cycle period must finish first
    run("n4_pre", 2);
    freq = 32'd9;
    run("n4_to_n9", 2 + 27);

    // degenerate divisors behave as 2
    freq = 32'd0;
    run("n0", 14);
    freq = 32'd1;
    run("n1", 12);

    // async reset while high with N=9
    freq = 32'd9;
    run("n9_settle", 12);
    for (int i = 0; i < 20 && !(exp_out && pos >= 1); i++) step("n9_seek");
    check("n9_high_before_rst", {63'd0, clk_out}, 64'd1);
    pulse_reset("rst_mid_high");
    run("n9_after_rst", 20);

    // random divisors, changes at random points, occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) freq = $urandom_range(0, 12);
      if ($urandom_range(0, 63) == 0) pulse_reset("rand_rst");
      step("random");
    end

    // maximal divisor: stays high, counter climbs without wrap
    freq = 32'hFFFF_FFFF;
    pulse_reset("big_rst");
    for (int i = 0; i < 1000; i++) begin
      step("big_out");
      check("big_cnt", {32'd0, dut.u_counter.cnt}, pos);
    end
    check("big_pos", pos, 64'd999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
